// File: rtl/traffic_sensor_cond_if.sv
// ---------------------------------------------------------------------------
// traffic_sensor_cond_if
// Signal bundle between the roadside detector conditioner and its
// environment (detector pads, the traffic-light controller, status readout).
//
//   sa_raw, sb_raw : raw asynchronous detector inputs, streets A and B
//   clr_cnt        : synchronous clear of both arrival counters
//   Ta, Tb         : registered traffic-present flags
//   car_a, car_b   : one-cycle arrival strobes
//   cnt_a, cnt_b   : saturating arrival counters (CNT_W bits)
//   state_a/b      : channel FSM state, debug visibility only
//
// Handshake: car_x is a valid-only strobe with no ready. It is high for
// exactly one clock per confirmed arrival, and cnt_x already holds the
// post-arrival count in that same cycle, so a consumer samples both
// together on any cycle where car_x is high.
//
// CNT_W must match the CNT_W of the traffic_sensor_cond instance.
// ---------------------------------------------------------------------------
interface traffic_sensor_cond_if #(
  parameter int CNT_W = 8
);
  logic             sa_raw;
  logic             sb_raw;
  logic             clr_cnt;
  logic             Ta;
  logic             Tb;
  logic             car_a;
  logic             car_b;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  logic [2:0]       state_a;
  logic [2:0]       state_b;

  // Environment side: drives the detectors and the clear, observes results.
  modport master (
    output sa_raw, sb_raw, clr_cnt,
    input  Ta, Tb, car_a, car_b, cnt_a, cnt_b, state_a, state_b
  );

  // Conditioner side.
  modport slave (
    input  sa_raw, sb_raw, clr_cnt,
    output Ta, Tb, car_a, car_b, cnt_a, cnt_b, state_a, state_b
  );
endinterface

// File: rtl/traffic_sensor_cond.sv
// ---------------------------------------------------------------------------
// traffic_sensor_cond
// Turns two raw vehicle-detector inputs into clean traffic-present flags for
// the downstream light controller. Each channel (A, B) is independent:
// 2-flop synchroniser -> debounce/hold FSM -> registered flag, plus an
// arrival strobe and a saturating arrival counter.
//
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : traffic_sensor_cond_if.slave (raw inputs, clr_cnt, Ta/Tb,
//           car_a/car_b, cnt_a/cnt_b, debug FSM states)
// ---------------------------------------------------------------------------
module traffic_sensor_cond #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int CNT_W           = 8
) (
  input logic                  clk,
  input logic                  reset,
  traffic_sensor_cond_if.slave bus
);

  // +1 keeps both widths >= 1 at the smallest legal parameter values.
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [DW-1:0]    D_ONE   = DW'(1);
  localparam logic [DW-1:0]    D_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0]    H_ONE   = HW'(1);
  localparam logic [HW-1:0]    H_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RISE_CHK = 3'd1,
    PRESENT  = 3'd2,
    FALL_CHK = 3'd3,
    HOLD     = 3'd4,
    REARM    = 3'd5
  } state_e;

  logic [1:0]       raw_w;
  logic [1:0]       t_w;
  logic [1:0]       car_w;
  logic [CNT_W-1:0] cnt_w   [2];
  state_e           state_w [2];

  assign raw_w = {bus.sb_raw, bus.sa_raw};

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic             s1_q, s2_q;
    state_e           state_q, state_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic [HW-1:0]    hcnt_q, hcnt_d;
    logic             t_q, t_d;
    logic             car_q, arrival;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
      if (reset) begin
        s1_q    <= 1'b0;
        s2_q    <= 1'b0;
        state_q <= IDLE;
        dcnt_q  <= '0;
        hcnt_q  <= '0;
        t_q     <= 1'b0;
        car_q   <= 1'b0;
        cnt_q   <= '0;
      end else begin
        s1_q    <= raw_w[g];
        s2_q    <= s1_q;
        state_q <= state_d;
        dcnt_q  <= dcnt_d;
        hcnt_q  <= hcnt_d;
        t_q     <= t_d;
        car_q   <= arrival;
        cnt_q   <= cnt_d;
      end
    end

    // s2_q is the only view of the detector the FSM ever uses.
    always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      hcnt_d  = hcnt_q;
      arrival = 1'b0;
      case (state_q)
        IDLE: begin
          if (s2_q) begin
            state_d = RISE_CHK;
            dcnt_d  = D_ONE;
          end
        end
        RISE_CHK: begin
          if (!s2_q) begin
            state_d = IDLE;
          end else if (dcnt_q == D_LAST) begin
            state_d = PRESENT;
            arrival = 1'b1;
          end else begin
            dcnt_d = dcnt_q + D_ONE;
          end
        end
        PRESENT: begin
          if (!s2_q) begin
            state_d = FALL_CHK;
            dcnt_d  = D_ONE;
          end
        end
        FALL_CHK: begin
          // A bounce back high is the same vehicle, not a new arrival.
          if (s2_q) begin
            state_d = PRESENT;
          end else if (dcnt_q == D_LAST) begin
            state_d = HOLD;
            hcnt_d  = '0;
          end else begin
            dcnt_d = dcnt_q + D_ONE;
          end
        end
        HOLD: begin
          // Detector activity takes priority over hold expiry.
          if (s2_q) begin
            state_d = REARM;
            dcnt_d  = D_ONE;
          end else if (hcnt_q == H_LAST) begin
            state_d = IDLE;
          end else begin
            hcnt_d = hcnt_q + H_ONE;
          end
        end
        REARM: begin
          // A short blip during hold restarts the full hold window.
          if (!s2_q) begin
            state_d = HOLD;
            hcnt_d  = '0;
          end else if (dcnt_q == D_LAST) begin
            state_d = PRESENT;
            arrival = 1'b1;
          end else begin
            dcnt_d = dcnt_q + D_ONE;
          end
        end
        default: state_d = IDLE;
      endcase

      t_d = (state_d != IDLE) && (state_d != RISE_CHK);

      // A clear that coincides with an arrival keeps that arrival.
      cnt_d = cnt_q;
      if (bus.clr_cnt) begin
        cnt_d = arrival ? CNT_ONE : '0;
      end else if (arrival && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end

    assign t_w[g]     = t_q;
    assign car_w[g]   = car_q;
    assign cnt_w[g]   = cnt_q;
    assign state_w[g] = state_q;
  end

  assign bus.Ta      = t_w[0];
  assign bus.Tb      = t_w[1];
  assign bus.car_a   = car_w[0];
  assign bus.car_b   = car_w[1];
  assign bus.cnt_a   = cnt_w[0];
  assign bus.cnt_b   = cnt_w[1];
  assign bus.state_a = state_w[0];
  assign bus.state_b = state_w[1];

endmodule

// File: tb/tb_traffic_sensor_cond.sv
// ---------------------------------------------------------------------------
// tb_traffic_sensor_cond
// Directed scenarios followed by randomized detector activity. A reference
// model built from debounced-level / hold-timer rules predicts Ta/Tb, the
// counters and arrival strobes; arrivals are pushed to expected queues and
// popped by a negedge monitor when the DUT strobes car_x.
// ---------------------------------------------------------------------------
module tb_traffic_sensor_cond;
  localparam int D    = 4;
  localparam int H    = 8;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  traffic_sensor_cond_if #(.CNT_W(CW)) bus ();

  traffic_sensor_cond #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .CNT_W          (CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [CW-1:0] exp_a_q[$];
  logic [CW-1:0] exp_b_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Channel level L flips only after D consecutive opposite sync samples.
  // A rise of L is an arrival. After L falls the flag is held for H further
  // low samples; a low sample following a high one restarts that window.
  bit m_s1[2], m_s2[2], m_lvl[2], m_prev[2], m_t[2];
  bit m_run_val[2];
  int m_run_len[2], m_hold[2], m_cnt[2];

  always @(posedge clk) begin
    bit sync, arr;
    logic [1:0] raw;
    raw = {bus.sb_raw, bus.sa_raw};
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_prev[c] = 0; m_t[c] = 0;
        m_run_val[c] = 0; m_run_len[c] = 0; m_hold[c] = 0; m_cnt[c] = 0;
      end
      exp_a_q.delete();
      exp_b_q.delete();
    end else begin
      for (int c = 0; c < 2; c++) begin
        sync    = m_s2[c];
        m_s2[c] = m_s1[c];
        m_s1[c] = raw[c];
        if (sync == m_run_val[c]) m_run_len[c]++;
        else begin m_run_val[c] = sync; m_run_len[c] = 1; end
        arr = 0;
        if (!m_lvl[c] && sync && m_run_len[c] >= D) begin
          m_lvl[c] = 1; arr = 1; m_hold[c] = 0;
        end else if (m_lvl[c] && !sync && m_run_len[c] >= D) begin
          m_lvl[c] = 0; m_hold[c] = H;
        end else if (!m_lvl[c] && m_hold[c] > 0 && !sync) begin
          if (m_prev[c]) m_hold[c] = H;
          else m_hold[c]--;
        end
        m_prev[c] = sync;
        m_t[c] = m_lvl[c] || (m_hold[c] > 0);
        if (bus.clr_cnt) m_cnt[c] = arr ? 1 : 0;
        else if (arr && m_cnt[c] < CMAX) m_cnt[c]++;
        if (arr) begin
          if (c == 0) exp_a_q.push_back(CW'(m_cnt[c]));
          else        exp_b_q.push_back(CW'(m_cnt[c]));
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [CW-1:0] e;
    check("Ta", bus.Ta, m_t[0]);
    check("Tb", bus.Tb, m_t[1]);
    check("cnt_a", bus.cnt_a, m_cnt[0]);
    check("cnt_b", bus.cnt_b, m_cnt[1]);
    if (bus.car_a !== 1'b0 || exp_a_q.size() != 0) begin
      if (exp_a_q.size() == 0) check("car_a_unexpected", bus.car_a, 0);
      else begin
        e = exp_a_q.pop_front();
        check("car_a_pulse", bus.car_a, 1);
        check("car_a_cnt", bus.cnt_a, e);
      end
    end
    if (bus.car_b !== 1'b0 || exp_b_q.size() != 0) begin
      if (exp_b_q.size() == 0) check("car_b_unexpected", bus.car_b, 0);
      else begin
        e = exp_b_q.pop_front();
        check("car_b_pulse", bus.car_b, 1);
        check("car_b_cnt", bus.cnt_b, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Counts negedges (the first one follows the first sampling edge) until
  // Ta equals want; -1 if the bound runs out.
  task automatic wait_ta(input logic want, input int limit, output int cycles);
    cycles = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (bus.Ta === want) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic drive(input logic a, input logic b, input int n);
    bus.sa_raw = a;
    bus.sb_raw = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr();
    bus.clr_cnt = 1'b1;
    @(negedge clk);
    bus.clr_cnt = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int   lat, drops;
  int   rleft[2];
  logic rlvl[2];

  initial begin
    reset = 1'b1;
    bus.sa_raw = 1'b1;
    bus.sb_raw = 1'b1;
    bus.clr_cnt = 1'b0;

    // Reset hold with both detectors high.
    repeat (3) @(negedge clk);
    check("rst_Ta", bus.Ta, 0);
    check("rst_Tb", bus.Tb, 0);
    check("rst_cnt_a", bus.cnt_a, 0);
    check("rst_car_b", bus.car_b, 0);
    reset = 1'b0;
    // Sampling edge k counts as 1; flag rises after edge k+D+1.
    wait_ta(1'b1, 20, lat);
    check("rst_release_rise_lat", lat, D + 2);
    check("rst_release_Tb", bus.Tb, 1);

    drive(1'b0, 1'b0, 0);
    wait_ta(1'b0, 40, lat);
    check("fall_lat", lat, D + 2 + H);
    check("fall_Tb", bus.Tb, 0);
    drive(1'b0, 1'b0, 4);

    // Glitch shorter than the debounce window.
    drive(1'b1, 1'b0, D - 1);
    drive(1'b0, 1'b0, 0);
    wait_ta(1'b1, 16, lat);
    check("glitch_no_rise", lat, -1);
    check("glitch_cnt_a", bus.cnt_a, 1);

    // Single car on A.
    drive(1'b1, 1'b0, 0);
    wait_ta(1'b1, 10, lat);
    check("car_rise_lat", lat, D + 2);
    drive(1'b1, 1'b0, 10 - lat);
    drive(1'b0, 1'b0, 0);
    wait_ta(1'b0, 40, lat);
    check("car_fall_lat", lat, D + 2 + H);
    check("car_cnt_a", bus.cnt_a, 2);

    // Clear alone.
    pulse_clr();
    check("clr_alone_a", bus.cnt_a, 0);
    check("clr_alone_b", bus.cnt_b, 0);

    // Re-arrival while holding.
    drive(1'b1, 1'b0, 10);
    drops = 0;
    bus.sa_raw = 1'b0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (bus.Ta !== 1'b1) drops++; end
    bus.sa_raw = 1'b1;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (bus.Ta !== 1'b1) drops++; end
    check("rearm_no_drop", drops, 0);
    drive(1'b0, 1'b0, 0);
    wait_ta(1'b0, 40, lat);
    check("rearm_fall_lat", lat, D + 2 + H);
    check("rearm_cnt_a", bus.cnt_a, 2);

    // Short blip while holding restarts the hold window, no arrival.
    pulse_clr();
    drive(1'b1, 1'b0, 10);
    drive(1'b0, 1'b0, 8);
    drive(1'b1, 1'b0, 2);
    drive(1'b0, 1'b0, 0);
    wait_ta(1'b0, 40, lat);
    check("blip_fall_lat", lat, H + 3);
    check("blip_cnt_a", bus.cnt_a, 1);

    // Saturation with a narrow counter.
    pulse_clr();
    for (int n = 0; n < 5; n++) begin
      drive(1'b1, 1'b0, 6);
      drive(1'b0, 1'b0, 16);
    end
    check("sat_cnt_a", bus.cnt_a, CMAX);
    // Clear lands on the same edge as the sixth arrival.
    drive(1'b1, 1'b0, D + 1);
    pulse_clr();
    check("clr_with_arrival", bus.cnt_a, 1);
    drive(1'b1, 1'b0, 2);
    drive(1'b0, 1'b0, 16);
    pulse_clr();
    check("clr_after_sat", bus.cnt_a, 0);

    // Independence, then reset during FALL_CHK.
    drive(1'b1, 1'b0, 10);
    check("indep_Ta", bus.Ta, 1);
    check("indep_Tb", bus.Tb, 0);
    check("indep_cnt_b", bus.cnt_b, 0);
    drive(1'b0, 1'b0, 3);
    check("fallchk_Ta_high", bus.Ta, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_Ta", bus.Ta, 0);
    check("mid_reset_cnt_a", bus.cnt_a, 0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 4);

    // Randomized activity on both channels.
    rleft[0] = 0;
    rleft[1] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < 2; c++) begin
        if (rleft[c] == 0) begin
          rlvl[c]  = 1'($urandom_range(0, 1));
          rleft[c] = $urandom_range(1, 14);
        end
        rleft[c]--;
      end
      bus.sa_raw  = rlvl[0];
      bus.sb_raw  = rlvl[1];
      bus.clr_cnt = ($urandom_range(0, 39) == 0);
      reset       = ($urandom_range(0, 699) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    bus.clr_cnt = 1'b0;
    drive(1'b0, 1'b0, 30);
    check("end_Ta_idle", bus.Ta, 0);
    check("end_Tb_idle", bus.Tb, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
